// File: rtl/iq_adc_tx.sv
// iq_adc_tx: producer side of the ADC_rdy sample interface.
// Buffers upstream I/Q samples in a small FIFO and presents each one on adc_i/adc_q
// with ADC_rdy held high for HOLD_CYCLES, then low for at least GAP_CYCLES, so the
// receiver's ready-edge detector sees exactly one rising edge per sample.
//
// Ports:
//   clk, resetn         clock; asynchronous active-low reset
//   sync_clr            synchronous flush: empties FIFO, aborts the current sample
//   in_valid/in_ready   upstream handshake (in_ready = FIFO not full)
//   in_i, in_q          upstream sample
//   ADC_rdy             registered sample strobe level
//   adc_i, adc_q        registered sample outputs
//   busy                FSM not idle or FIFO not empty
//   test_mode           (ADC_TX_TESTPAT_EN only) emit a ramp instead of FIFO data
//
// Optional feature macro: ADC_TX_TESTPAT_EN (adds test_mode port and ramp generator).
module iq_adc_tx #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              sync_clr,
`ifdef ADC_TX_TESTPAT_EN
    input  logic              test_mode,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_i,
    input  logic [DATA_W-1:0] in_q,
    output logic              ADC_rdy,
    output logic [DATA_W-1:0] adc_i,
    output logic [DATA_W-1:0] adc_q,
    output logic              busy
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam int unsigned CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {StIdle, StAssert, StGap} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   mem_i [DEPTH];
    logic [DATA_W-1:0]   mem_q [DEPTH];
    // Sample captured at the IDLE->ASSERT transition, launched by the output stage.
    logic [DATA_W-1:0]   smp_i_q, smp_i_d, smp_q_q, smp_q_d;
    logic                adc_rdy_q, adc_rdy_d;
    logic [DATA_W-1:0]   adc_i_q, adc_i_d, adc_q_q, adc_q_d;
    logic                empty, full, push, pop;
`ifdef ADC_TX_TESTPAT_EN
    logic [DATA_W-1:0]   ramp_q, ramp_d;
`endif

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Full blocks writes even if a pop happens in the same cycle.
    assign push  = in_valid && !full && !sync_clr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_i[wr_ptr_q[AW-1:0]] <= in_i;
            mem_q[wr_ptr_q[AW-1:0]] <= in_q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            smp_i_q   <= '0;
            smp_q_q   <= '0;
            adc_rdy_q <= 1'b0;
            adc_i_q   <= '0;
            adc_q_q   <= '0;
`ifdef ADC_TX_TESTPAT_EN
            ramp_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            smp_i_q   <= smp_i_d;
            smp_q_q   <= smp_q_d;
            adc_rdy_q <= adc_rdy_d;
            adc_i_q   <= adc_i_d;
            adc_q_q   <= adc_q_d;
`ifdef ADC_TX_TESTPAT_EN
            ramp_q    <= ramp_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        smp_i_d = smp_i_q;
        smp_q_d = smp_q_q;
        pop     = 1'b0;
`ifdef ADC_TX_TESTPAT_EN
        ramp_d  = ramp_q;
`endif
        if (sync_clr) begin
            state_d = StIdle;
            cnt_d   = '0;
`ifdef ADC_TX_TESTPAT_EN
            ramp_d  = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
`ifdef ADC_TX_TESTPAT_EN
                    if (test_mode) begin
                        smp_i_d = ramp_q;
                        smp_q_d = ~ramp_q;
                        ramp_d  = ramp_q + 1'b1;
                        cnt_d   = CW'(HOLD_CYCLES - 1);
                        state_d = StAssert;
                    end else
`endif
                    if (!empty) begin
                        pop     = 1'b1;
                        smp_i_d = mem_i[rd_ptr_q[AW-1:0]];
                        smp_q_d = mem_q[rd_ptr_q[AW-1:0]];
                        cnt_d   = CW'(HOLD_CYCLES - 1);
                        state_d = StAssert;
                    end
                end
                StAssert: begin
                    if (cnt_q == '0) begin
                        cnt_d   = CW'(GAP_CYCLES - 1);
                        state_d = StGap;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                StGap: begin
                    if (cnt_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        if (sync_clr) begin
            rd_ptr_d = wr_ptr_q;
        end
    end

    // Output logic: strobe follows ASSERT by one register stage; data only
    // reloads while the strobe is high, so it holds through GAP and IDLE.
    always_comb begin
        adc_rdy_d = (state_q == StAssert) && !sync_clr;
        adc_i_d   = adc_rdy_d ? smp_i_q : adc_i_q;
        adc_q_d   = adc_rdy_d ? smp_q_q : adc_q_q;
        in_ready  = !full;
        busy      = (state_q != StIdle) || !empty;
    end

    assign ADC_rdy = adc_rdy_q;
    assign adc_i   = adc_i_q;
    assign adc_q   = adc_q_q;

endmodule

// File: doc/iq_adc_tx.md
Name: iq_adc_tx

Overview:
- Producer side of the ADC_rdy sample interface: supplies I/Q samples and the ADC_rdy level strobe that the demodulator's ready-edge detector consumes.
- Buffers upstream samples in a small FIFO.
- Presents each sample on adc_i/adc_q with ADC_rdy held high for a programmable number of cycles, then low for a programmable gap, so every sample yields exactly one rising edge at the receiver.
- Used as the ADC model/bridge in front of iq_demod and as the stimulus source in system benches.

Parameters:
- DATA_W, 8, width of each I and Q sample.
- DEPTH, 4, FIFO entries; power of 2, >=2.
- HOLD_CYCLES, 2, cycles ADC_rdy stays high per sample; >=1.
- GAP_CYCLES, 1, minimum cycles ADC_rdy stays low between samples; >=1.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- sync_clr  in  1  synchronous flush: empties FIFO, aborts current sample
- in_valid  in  1  upstream sample valid
- in_ready  out  1  FIFO can accept (not full)
- in_i  in  DATA_W  upstream I sample
- in_q  in  DATA_W  upstream Q sample
- ADC_rdy  out  1  sample strobe level toward the receiver, registered
- adc_i  out  DATA_W  I sample, registered
- adc_q  out  DATA_W  Q sample, registered
- busy  out  1  FSM not in IDLE, or FIFO not empty

Behaviour:
- Reset (resetn low, async):
  - FSM enters IDLE; FIFO is empty; hold/gap counter = 0.
  - ADC_rdy=0, adc_i=0, adc_q=0, in_ready=1, busy=0.
- FIFO:
  - Write on in_valid & in_ready.
  - in_ready = !full, derived from registered state. When full, no write is accepted even if a pop occurs in the same cycle.
  - A simultaneous push and pop when not full is allowed; the level is unchanged.
  - Pointers are log2(DEPTH)+1 bits and wrap naturally.
- FSM states IDLE, ASSERT, GAP:
  - IDLE:
    - If FIFO is not empty: pop, load adc_i/adc_q from the head entry, set ADC_rdy=1, counter=HOLD_CYCLES-1, go to ASSERT.
    - Otherwise stay in IDLE with ADC_rdy=0.
  - ASSERT:
    - ADC_rdy=1.
    - If counter=0: set ADC_rdy=0, counter=GAP_CYCLES-1, go to GAP.
    - Otherwise decrement the counter.
  - GAP:
    - ADC_rdy=0.
    - If counter=0, go to IDLE; otherwise decrement the counter.
- Timing:
  - adc_i/adc_q change only on the IDLE->ASSERT edge. They hold through ASSERT, GAP and IDLE until the next load.
  - ADC_rdy is high for exactly HOLD_CYCLES cycles per sample.
  - Minimum sample period is HOLD_CYCLES+GAP_CYCLES+1 cycles.
  - Latency: a sample accepted at clock edge E0 into an empty FIFO with the FSM in IDLE drives ADC_rdy=1 and the new data after edge E2.
- Ordering: samples are emitted strictly in FIFO order; none are dropped or duplicated.
- sync_clr (sampled at the clock edge, priority over everything):
  - Empties the FIFO and moves the FSM to IDLE.
  - ADC_rdy=0 after the edge; adc_i/adc_q keep their last value.
  - No write is accepted in a sync_clr cycle.
- Async reset mid-sample: ADC_rdy drops immediately; the FIFO contents are lost.
- busy = (state!=IDLE) | !empty, combinational from registered state.

Optional Feature:
- Macro ADC_TX_TESTPAT_EN.
- Defined:
  - Adds input port test_mode (1 bit) and an internal DATA_W-bit ramp counter, reset to 0.
  - While test_mode=1, IDLE does not consult or pop the FIFO. It loads adc_i=ramp and adc_q=~ramp, goes to ASSERT, and increments ramp (wrapping at 2^DATA_W).
  - The FIFO still accepts writes; sync_clr also clears ramp.
  - test_mode is sampled only in IDLE; a change mid-sample takes effect at the next IDLE.
- Undefined: no test_mode port and no ramp logic; samples always come from the FIFO.

Test Plan:
- Single sample, defaults: push I=0x12, Q=0x34 at edge E0 -> after E2 ADC_rdy=1 and adc_i=0x12, adc_q=0x34; ADC_rdy high for exactly 2 cycles, then low for 1 cycle; busy returns to 0.
- Back-to-back: push 6 samples 1..6 continuously -> in_ready drops after the FIFO holds 4 entries; outputs show 1..6 in order, one rising ADC_rdy edge every 4 cycles, no loss.
- Parameter sweep: HOLD_CYCLES=1, GAP_CYCLES=3 -> ADC_rdy pattern 1,0,0,0,0 repeating (period 5) under a continuous supply.
- Flush: sync_clr asserted on the 2nd ASSERT cycle with 3 samples queued -> ADC_rdy=0 next cycle; FIFO empty; in_ready=1; busy=0; no further strobes.
- Async reset mid-GAP: resetn pulsed low -> all outputs return to reset values immediately; the next pushed sample appears with 2-cycle latency.
- With ADC_TX_TESTPAT_EN and test_mode=1: 3 strobes -> (adc_i, adc_q) = (0x00,0xFF), (0x01,0xFE), (0x02,0xFD); a pre-queued FIFO entry is still present afterward.
